// File: rtl/stream_seq_checker_if.sv
// Valid/ready stream bundle between a data source and a sink.
interface stream_seq_checker_if #(
   parameter int DW = 32
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/stream_seq_checker.sv
// Stream sink: throttles ready with an LFSR, counts beats and checks
// that the payload is an incrementing sequence starting at zero.
module stream_seq_checker #(
   parameter int          DW         = 32,
   parameter int unsigned NUM_BEATS  = 100,
   parameter bit          READY_MODE = 1'b1,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_run,
   stream_seq_checker_if.slave  s,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [31:0]          o_beat_cnt,
   output logic [15:0]          o_err_cnt,
   output logic                 o_err_flag,
   output logic [31:0]          o_first_err_idx,
   output logic [DW-1:0]        o_first_err_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [31:0] LAST = 32'(NUM_BEATS - 1);

   logic [1:0]    state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic          ready_q, ready_d;
   logic [31:0]   beat_q, beat_d;
   logic [15:0]   err_q, err_d;
   logic          flag_q, flag_d;
   logic [31:0]   fidx_q, fidx_d;
   logic [DW-1:0] fdat_q, fdat_d;
   logic          hs;
   logic          mis;

   assign hs  = s.s_valid & ready_q;
   assign mis = s.s_data != DW'(beat_q);

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      beat_d  = beat_q;
      err_d   = err_q;
      flag_d  = flag_q;
      fidx_d  = fidx_q;
      fdat_d  = fdat_q;
      unique case (state_q)
         IDLE: begin
            if (i_run) begin
               state_d = RUN;
               lfsr_d  = LFSR_SEED;
               beat_d  = '0;
               err_d   = '0;
               flag_d  = 1'b0;
               fidx_d  = '0;
               fdat_d  = '0;
            end
         end
         RUN: begin
            // Galois step: shift right, fold taps in when bit 0 falls out
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            if (hs) begin
               beat_d = beat_q + 32'd1;
               if (mis) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  flag_d = 1'b1;
                  if (!flag_q) begin
                     fidx_d = beat_q;
                     fdat_d = s.s_data;
                  end
               end
               if (beat_q == LAST) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Ready tracks bit 0 of the LFSR value being loaded this edge
      if (state_d == RUN) ready_d = READY_MODE ? lfsr_d[0] : 1'b1;
      else                ready_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lfsr_q  <= LFSR_SEED;
         ready_q <= 1'b0;
         beat_q  <= '0;
         err_q   <= '0;
         flag_q  <= 1'b0;
         fidx_q  <= '0;
         fdat_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         ready_q <= ready_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         flag_q  <= flag_d;
         fidx_q  <= fidx_d;
         fdat_q  <= fdat_d;
      end
   end

   assign s.s_ready        = ready_q;
   assign o_busy           = state_q == RUN;
   assign o_done           = state_q == DONE;
   assign o_beat_cnt       = beat_q;
   assign o_err_cnt        = err_q;
   assign o_err_flag       = flag_q;
   assign o_first_err_idx  = fidx_q;
   assign o_first_err_data = fdat_q;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker across four parameter sets.
// Inputs change and outputs are sampled on the falling edge.
module tb_stream_seq_checker;

   logic clk;
   logic reset;

   logic        run [4];
   logic        vld [4];
   logic [31:0] dat [4];

   wire         rdy  [4];
   wire         busy [4];
   wire         done [4];
   wire  [31:0] bcnt [4];
   wire  [15:0] ecnt [4];
   wire         eflg [4];
   wire  [31:0] fidx [4];
   wire  [31:0] fdat [4];

   wire  [31:0] fdat0, fdat1, fdat3;
   wire  [7:0]  fdat2;

   int checks = 0;
   int errors = 0;

   int          bad0  = -1;
   int          bad1  = -1;
   logic [31:0] badv0 = '0;
   logic [31:0] badv1 = '0;

   stream_seq_checker_if #(.DW(32)) if0 ();
   stream_seq_checker_if #(.DW(32)) if1 ();
   stream_seq_checker_if #(.DW(8))  if2 ();
   stream_seq_checker_if #(.DW(32)) if3 ();

   assign if0.s_valid = vld[0];
   assign if1.s_valid = vld[1];
   assign if2.s_valid = vld[2];
   assign if3.s_valid = vld[3];
   assign if0.s_data  = dat[0];
   assign if1.s_data  = dat[1];
   assign if2.s_data  = dat[2][7:0];
   assign if3.s_data  = dat[3];
   assign rdy[0]      = if0.s_ready;
   assign rdy[1]      = if1.s_ready;
   assign rdy[2]      = if2.s_ready;
   assign rdy[3]      = if3.s_ready;
   assign fdat[0]     = fdat0;
   assign fdat[1]     = fdat1;
   assign fdat[2]     = {24'h0, fdat2};
   assign fdat[3]     = fdat3;

   stream_seq_checker #(
      .DW(32), .NUM_BEATS(100), .READY_MODE(1'b0), .LFSR_SEED(16'hACE1)
   ) u0 (
      .clk(clk), .reset(reset), .i_run(run[0]), .s(if0.slave),
      .o_busy(busy[0]), .o_done(done[0]), .o_beat_cnt(bcnt[0]),
      .o_err_cnt(ecnt[0]), .o_err_flag(eflg[0]),
      .o_first_err_idx(fidx[0]), .o_first_err_data(fdat0)
   );

   stream_seq_checker #(
      .DW(32), .NUM_BEATS(100), .READY_MODE(1'b1), .LFSR_SEED(16'hACE1)
   ) u1 (
      .clk(clk), .reset(reset), .i_run(run[1]), .s(if1.slave),
      .o_busy(busy[1]), .o_done(done[1]), .o_beat_cnt(bcnt[1]),
      .o_err_cnt(ecnt[1]), .o_err_flag(eflg[1]),
      .o_first_err_idx(fidx[1]), .o_first_err_data(fdat1)
   );

   stream_seq_checker #(
      .DW(8), .NUM_BEATS(300), .READY_MODE(1'b0), .LFSR_SEED(16'hACE1)
   ) u2 (
      .clk(clk), .reset(reset), .i_run(run[2]), .s(if2.slave),
      .o_busy(busy[2]), .o_done(done[2]), .o_beat_cnt(bcnt[2]),
      .o_err_cnt(ecnt[2]), .o_err_flag(eflg[2]),
      .o_first_err_idx(fidx[2]), .o_first_err_data(fdat2)
   );

   stream_seq_checker #(
      .DW(32), .NUM_BEATS(1), .READY_MODE(1'b0), .LFSR_SEED(16'hACE1)
   ) u3 (
      .clk(clk), .reset(reset), .i_run(run[3]), .s(if3.slave),
      .o_busy(busy[3]), .o_done(done[3]), .o_beat_cnt(bcnt[3]),
      .o_err_cnt(ecnt[3]), .o_err_flag(eflg[3]),
      .o_first_err_idx(fidx[3]), .o_first_err_data(fdat3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // One run on instance u; returns the number of cycles spent in RUN.
   task automatic do_run(input int u, input int nb, input bit rndv,
                         input int rst_at, input bit poke,
                         input logic [31:0] mask, output int cyc);
      int          k;
      int          dones;
      bit          saw0, saw1, v, hs, aborted;
      logic [31:0] d;
      k = 0; dones = 0; saw0 = 0; saw1 = 0; aborted = 0; cyc = 0;
      run[u] = 1'b1;
      @(negedge clk);
      run[u] = 1'b0;
      check("start_busy", busy[u], 1);
      while (k < nb && cyc < 20000 && !aborted) begin
         if (rdy[u]) saw1 = 1; else saw0 = 1;
         if (done[u]) dones++;
         v = rndv ? 1'($urandom_range(1, 0)) : 1'b1;
         if (k == bad0)      d = badv0;
         else if (k == bad1) d = badv1;
         else                d = 32'(k) & mask;
         vld[u] = v;
         dat[u] = d;
         run[u] = poke && (cyc % 7 == 3);
         hs = v & rdy[u];
         @(negedge clk);
         cyc++;
         if (hs) k++;
         if (hs && k == rst_at) begin
            vld[u] = 1'b0;
            run[u] = 1'b0;
            reset  = 1'b1;
            @(negedge clk);
            reset  = 1'b0;
            check("rst_ready", rdy[u], 0);
            check("rst_busy", busy[u], 0);
            check("rst_done", done[u], 0);
            check("rst_beats", bcnt[u], 0);
            check("rst_errs", ecnt[u], 0);
            check("rst_flag", eflg[u], 0);
            @(negedge clk);
            check("rst_nodone", done[u], 0);
            aborted = 1;
         end
      end
      vld[u] = 1'b0;
      run[u] = 1'b0;
      if (!aborted) begin
         check("beats_seen", k, nb);
         check("done_in_run", dones, 0);
         check("done_pulse", done[u], 1);
         check("done_ready", rdy[u], 0);
         check("done_busy", busy[u], 0);
         check("done_bcnt", bcnt[u], nb);
         if (rndv) begin
            check("saw_ready0", saw0, 1);
            check("saw_ready1", saw1, 1);
         end
         @(negedge clk);
         check("done_clear", done[u], 0);
         vld[u] = 1'b1;
         repeat (3) begin
            @(negedge clk);
            check("idle_ready", rdy[u], 0);
            check("idle_bcnt", bcnt[u], nb);
         end
         vld[u] = 1'b0;
      end
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 4; i++) begin
         run[i] = 1'b0;
         vld[i] = 1'b0;
         dat[i] = '0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("reset_ready", rdy[i], 0);
         check("reset_busy", busy[i], 0);
         check("reset_done", done[i], 0);
         check("reset_bcnt", bcnt[i], 0);
         check("reset_ecnt", ecnt[i], 0);
         check("reset_flag", eflg[i], 0);
         check("reset_fidx", fidx[i], 0);
         check("reset_fdat", fdat[i], 0);
      end

      do_run(0, 100, 1'b0, -1, 1'b0, 32'hFFFF_FFFF, cyc);
      check("smoke_cycles", cyc, 100);
      check("smoke_ecnt", ecnt[0], 0);
      check("smoke_flag", eflg[0], 0);

      do_run(1, 100, 1'b1, -1, 1'b0, 32'hFFFF_FFFF, cyc);
      check("rand_ecnt", ecnt[1], 0);
      check("rand_flag", eflg[1], 0);

      bad0 = 37; badv0 = 32'hDEAD;
      bad1 = 60; badv1 = 32'h0;
      do_run(0, 100, 1'b0, -1, 1'b0, 32'hFFFF_FFFF, cyc);
      check("mis_ecnt", ecnt[0], 2);
      check("mis_flag", eflg[0], 1);
      check("mis_fidx", fidx[0], 37);
      check("mis_fdat", fdat[0], 32'hDEAD);
      bad0 = -1;
      bad1 = -1;

      do_run(0, 100, 1'b0, 50, 1'b0, 32'hFFFF_FFFF, cyc);
      do_run(0, 100, 1'b0, -1, 1'b0, 32'hFFFF_FFFF, cyc);
      check("rerun_cycles", cyc, 100);
      check("rerun_ecnt", ecnt[0], 0);
      check("rerun_flag", eflg[0], 0);
      check("rerun_fidx", fidx[0], 0);

      do_run(2, 300, 1'b0, -1, 1'b1, 32'h0000_00FF, cyc);
      check("wrap_cycles", cyc, 300);
      check("wrap_ecnt", ecnt[2], 0);
      check("wrap_flag", eflg[2], 0);

      do_run(3, 1, 1'b0, -1, 1'b0, 32'hFFFF_FFFF, cyc);
      check("single_cycles", cyc, 1);
      check("single_ecnt", ecnt[3], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_seq_checker.md
# stream_seq_checker

Synthesizable consumer end of a valid/ready stream: drives `s_ready` with a programmable backpressure pattern, accepts a fixed number of beats, and checks that the data is an incrementing sequence starting at 0. It sits downstream of FIFO/skid-buffer blocks, both on-chip for self-test and in benches. It reports completion, beat count, and error statistics, including capture of the first mismatch.

## Interface
- `DW`, 32: data width.
- `NUM_BEATS`, 100: beats accepted per run; range 1..2^32-1.
- `READY_MODE`, 1: 0 = `s_ready` always high in RUN; 1 = `s_ready` follows the LFSR bit.
- `LFSR_SEED`, 16'hACE1: LFSR load value on start; must be nonzero.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `i_run` in 1: start pulse; sampled only in IDLE.
- `s_valid` in 1: upstream valid.
- `s_ready` out 1: registered ready.
- `s_data` in DW: upstream data.
- `o_busy` out 1: high while state is RUN.
- `o_done` out 1: one-cycle pulse after the last beat.
- `o_beat_cnt` out 32: handshakes accepted in the current/last run.
- `o_err_cnt` out 16: mismatch count; saturates at 16'hFFFF.
- `o_err_flag` out 1: sticky; high once any mismatch occurs in the run.
- `o_first_err_idx` out 32: beat index of the first mismatch.
- `o_first_err_data` out DW: `s_data` value at the first mismatch.

## Operation
- Handshake: `hs = s_valid & s_ready`. Data is consumed only on `hs`.
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on `i_run`. Same edge: clear `o_beat_cnt`, `o_err_cnt`, `o_err_flag`, `o_first_err_*`; load the LFSR with `LFSR_SEED`.
  - RUN -> DONE on `hs` when `o_beat_cnt == NUM_BEATS-1`; otherwise stay in RUN.
  - DONE -> IDLE unconditionally.
- `i_run` in RUN or DONE is ignored.
- LFSR: 16-bit Galois, taps mask 16'hB400. It advances every cycle in RUN and holds otherwise.
- `s_ready` register:
  - If next state is RUN: `s_ready <= READY_MODE ? lfsr[0] : 1`.
  - Else: `s_ready <= 0`.
  - Ready may drop without `s_valid`; this is legal for a sink.
- Check on each `hs`:
  - expected = `o_beat_cnt[DW-1:0]`. When DW < 32, the expected value wraps modulo 2^DW.
  - On mismatch: `o_err_cnt` +1 (saturating) and `o_err_flag <= 1`.
  - On the first mismatch only (`o_err_flag` still 0): capture `o_first_err_idx <= o_beat_cnt` and `o_first_err_data <= s_data`.
  - `o_beat_cnt` +1 on every `hs`, match or not.
- Result registers hold their values through DONE/IDLE until the next `i_run`.
- `o_done = (state == DONE)`.
- `o_busy = (state == RUN)`.

## Timing
- Reset value of every output is 0; state resets to IDLE and the LFSR to `LFSR_SEED`.
- Reset mid-run: state -> IDLE, `s_ready` 0 the next cycle, all counters 0, no `o_done`.
- Start latency: `i_run` sampled at edge T gives `o_busy` = 1 and the first possible `s_ready` = 1 in cycle T+1.
- Completion: last `hs` at edge E gives `s_ready` = 0 and `o_done` = 1 in cycle E+1, and `o_busy` = 0 in cycle E+1. `o_done` = 0 in cycle E+2.
- No beat is accepted beyond `NUM_BEATS`; `s_ready` is never high outside RUN.
- `NUM_BEATS = 1`: the first `hs` goes directly to DONE.
- Error count saturation: `o_err_cnt` holds at 16'hFFFF; `o_err_flag` stays 1.

## Test plan
- **Always-ready smoke.** `READY_MODE=0`, source always valid with data 0..99, `i_run` at edge T.
  - Required: 100 consecutive handshakes in T+1..T+100; `o_done` high only in T+101.
  - Required: `o_beat_cnt` = 100, `o_err_cnt` = 0, `o_err_flag` = 0.
- **Random both sides.** `READY_MODE=1`, source valid random 0/1.
  - Required: exactly 100 handshakes, then `o_done`.
  - Required: `s_ready` observed both 0 and 1; no errors; `s_ready` = 0 after `o_done`.
- **Mismatch capture.** Beat 37 carries 32'hDEAD, beat 60 carries 32'h0.
  - Required: `o_err_cnt` = 2, `o_err_flag` = 1.
  - Required: `o_first_err_idx` = 37, `o_first_err_data` = 32'hDEAD.
- **Reset mid-run.** Assert `reset` for 1 cycle after beat 50.
  - Required: next cycle `s_ready` = 0, `o_busy` = 0, all counters 0, no `o_done` pulse.
  - Required: a new `i_run` then completes 100 clean beats.
- **Wrap and ignored start.** DW=8, `NUM_BEATS=300`, data = `beat_idx mod 256`, plus extra `i_run` pulses during RUN.
  - Required: 0 errors across the 255->0 wrap; the extra pulses have no effect.
  - Required: `o_beat_cnt` = 300 and a single `o_done`.
- **Single beat.** `NUM_BEATS=1`, data 0.
  - Required: `o_done` in the cycle after the only `hs`; `o_beat_cnt` = 1.
